exposure_seq_param: RTL and testbench
=====================================

EXPOSURE_SEQ_PARAM -- requirements
Module: exposure_seq_param

Interface
REQ-001 Parameter ROW_W, default 10: ROWADD width.
REQ-002 Parameter NUM_ROWS, default 320: rows per subframe; multiple of ROW_STEP.
REQ-003 Parameter ROW_STEP, default 8: row-address increment per row group.
REQ-004 Parameter STREAM_SLOTS, default 3: T_row slots per row group, range 1..15.
REQ-005 Parameter CNT_W, default 32: width of all timing inputs and internal counters.
REQ-006 Port CLKM, input, 1: sole clock, rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Inputs, each CNT_W wide:
- T_reset, Tgl_res, T_row, Texp_ctrl, T_stdby: phase lengths in cycles.
- T_des_st, T_des_len, T_sync_st, T_sync_len, T_mask_st, T_mask_len, T_hold: in-slot window offsets/lengths.
REQ-009 Input NUM_SUB, CNT_W: subframes per frame; 0 treated as 1.
REQ-010 Input cont_mode, 1: rearm automatically after each frame.
REQ-011 Input start, 1: single-cycle frame request when cont_mode=0.
REQ-012 Input abort, 1: synchronous frame abort.
REQ-013 Input re_busy, 1: readout engine busy.
REQ-014 Output trigger_o, 1: frame-done handshake to readout.
REQ-015 Outputs, 1 bit each: STDBY, EXP, PIXDRAIN, PIXGLOB_RES, PIXVTG_GLOB, PIXREAD_EN, PIXROWMASK, DES, SYNC, MASK_EN, EN_STREAM: pixel array controls.
REQ-016 Output ROWADD, ROW_W: row address.
REQ-017 Output busy, 1: high in any state other than IDLE and DONE.
REQ-018 Output sub_idx, CNT_W: completed subframes in the current frame.

Function
REQ-019 States SHALL be IDLE, RST, GLRES, ROWS, EXPCTRL, STBY, DONE.
REQ-020 IDLE->RST SHALL occur when re_busy=0 and (start=1 or cont_mode=1).
REQ-021 RST SHALL last max(T_reset,1) cycles, clear all counters, then go to GLRES.
REQ-022 GLRES SHALL last max(Tgl_res,1) cycles, then go to ROWS with group=0, slot=0.
REQ-023 ROWS timing:
- Each slot lasts max(T_row,1) cycles; slot counter c runs 0..T_row-1.
- slot wraps at STREAM_SLOTS-1.
- group wraps at NUM_ROWS/ROW_STEP-1.
- After the last slot of the last group, go to EXPCTRL.
REQ-024 EXPCTRL SHALL last max(Texp_ctrl,1) cycles and increment sub_idx on exit; if sub_idx+1 >= max(NUM_SUB,1), go to STBY, else go to ROWS with group=0.
REQ-025 STBY SHALL last max(T_stdby,1) cycles, then go to DONE.
REQ-026 DONE handshake:
- trigger_o=1 while in DONE.
- DONE->IDLE on the first cycle re_busy=1.
- trigger_o is 0 in all other states.
REQ-027 abort=1 in any state except IDLE SHALL force IDLE next cycle with idle outputs and no trigger_o; abort has priority over every other transition.
REQ-028 All outputs SHALL be registered: value at cycle n+1 decodes state and counters at cycle n.
REQ-029 Idle output values: EXP=1, PIXDRAIN=1, PIXREAD_EN=1; all others 0; ROWADD=0.
REQ-030 RST output values: STDBY=1, EXP=1, PIXDRAIN=1, PIXGLOB_RES=1, PIXVTG_GLOB=1; all others 0.
REQ-031 GLRES output values: STDBY=1, PIXGLOB_RES=1; all others 0.
REQ-032 ROWS output values:
- STDBY=1; EN_STREAM=1.
- PIXROWMASK=1 in slot 0 only.
- DES=1 when T_des_st <= c < T_des_st+T_des_len, in every slot.
- SYNC=1 when T_sync_st <= c < T_sync_st+T_sync_len, slot 0 only.
- MASK_EN=1 when T_mask_st <= c < T_mask_st+T_mask_len, slot 0 only.
- ROWADD holds its previous value while c < T_hold in slot 0, else group*ROW_STEP.
REQ-033 EXPCTRL and STBY output values: STDBY=1 in EXPCTRL and 0 in STBY; all other controls 0; ROWADD held.
REQ-034 Window sums and products SHALL be computed at CNT_W+1 bits so they cannot wrap; a zero-length window never asserts.
REQ-035 Timing inputs SHALL be sampled continuously; changes take effect at the next comparison. Software changes them only in IDLE.

Reset
REQ-036 While rst=1, state=IDLE, all counters=0, sub_idx=0, trigger_o=0, busy=0, and outputs take idle values asynchronously.
REQ-037 Reset asserted mid-frame SHALL discard the frame; after release the block waits for a fresh IDLE->RST condition.

Verification
REQ-038 Full frame: NUM_ROWS=16, ROW_STEP=8, STREAM_SLOTS=3, T_row=10, NUM_SUB=2, start pulse -> 2x(2x3x10) ROWS cycles, ROWADD sequence 0,8,0,8, trigger_o rises after STBY.
REQ-039 Zero lengths: T_reset=0, Texp_ctrl=0, NUM_SUB=0 -> each phase lasts 1 cycle, exactly one subframe runs.
REQ-040 Windows: T_des_st=2, T_des_len=3, T_row=10 -> DES high at c=2..4 (outputs 1 cycle later) in every slot; SYNC and MASK_EN appear in slot 0 only.
REQ-041 Handshake: re_busy held 0 in DONE -> trigger_o stays 1; re_busy=1 -> IDLE next cycle; with cont_mode=1 and re_busy then 0 -> RST.
REQ-042 Abort in ROWS at group 1 -> IDLE next cycle, EXP=1, PIXDRAIN=1, trigger_o never asserted.
REQ-043 Async rst pulse mid-EXPCTRL, no clock edge -> outputs at idle values immediately, sub_idx=0.

Source files
------------

// File: rtl/exposure_seq_param.sv
// Exposure sequencer: drives the pixel array through reset, global reset,
// streamed row groups, exposure control and standby for one or more
// subframes, then hands the finished frame to the readout engine.
module exposure_seq_param #(
    parameter int ROW_W        = 10,
    parameter int NUM_ROWS     = 320,
    parameter int ROW_STEP     = 8,
    parameter int STREAM_SLOTS = 3,
    parameter int CNT_W        = 32
) (
    input  logic             CLKM,
    input  logic             rst,
    input  logic [CNT_W-1:0] T_reset,
    input  logic [CNT_W-1:0] Tgl_res,
    input  logic [CNT_W-1:0] T_row,
    input  logic [CNT_W-1:0] Texp_ctrl,
    input  logic [CNT_W-1:0] T_stdby,
    input  logic [CNT_W-1:0] T_des_st,
    input  logic [CNT_W-1:0] T_des_len,
    input  logic [CNT_W-1:0] T_sync_st,
    input  logic [CNT_W-1:0] T_sync_len,
    input  logic [CNT_W-1:0] T_mask_st,
    input  logic [CNT_W-1:0] T_mask_len,
    input  logic [CNT_W-1:0] T_hold,
    input  logic [CNT_W-1:0] NUM_SUB,
    input  logic             cont_mode,
    input  logic             start,
    input  logic             abort,
    input  logic             re_busy,
    output logic             trigger_o,
    output logic             STDBY,
    output logic             EXP,
    output logic             PIXDRAIN,
    output logic             PIXGLOB_RES,
    output logic             PIXVTG_GLOB,
    output logic             PIXREAD_EN,
    output logic             PIXROWMASK,
    output logic             DES,
    output logic             SYNC,
    output logic             MASK_EN,
    output logic             EN_STREAM,
    output logic [ROW_W-1:0] ROWADD,
    output logic             busy,
    output logic [CNT_W-1:0] sub_idx
);

    localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NUM_ROWS / ROW_STEP - 1);
    localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(STREAM_SLOTS - 1);
    localparam logic [CNT_W:0]   STEP_X     = (CNT_W+1)'(ROW_STEP);
    localparam logic [CNT_W:0]   ONE_X      = (CNT_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_GLRES, S_ROWS, S_EXPCTRL, S_STBY, S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] slot;
    logic [CNT_W-1:0] grp;

    logic [CNT_W-1:0] ph_len;
    logic             ph_done;
    logic             last_sub;
    logic             d_stdby, d_exp, d_drain, d_glob_res, d_vtg_glob, d_read_en;
    logic             d_rowmask, d_des, d_sync, d_mask_en, d_en_stream;
    logic [ROW_W-1:0] d_rowadd;

    // True on the final cycle of a phase; a zero length behaves as one cycle.
    function automatic logic phase_last(input logic [CNT_W-1:0] c,
                                        input logic [CNT_W-1:0] len);
        logic [CNT_W:0] len_x;
        len_x = (len == '0) ? ONE_X : {1'b0, len};
        return ({1'b0, c} + ONE_X) >= len_x;
    endfunction

    // Window test at one extra bit so st+len cannot wrap; len=0 never hits.
    function automatic logic in_window(input logic [CNT_W-1:0] c,
                                       input logic [CNT_W-1:0] st,
                                       input logic [CNT_W-1:0] len);
        logic [CNT_W:0] end_x;
        end_x = {1'b0, st} + {1'b0, len};
        return ({1'b0, c} >= {1'b0, st}) && ({1'b0, c} < end_x);
    endfunction

    // Select the length of the current phase and detect its last cycle.
    always_comb begin
        ph_len = '0;
        case (state)
            S_RST:     ph_len = T_reset;
            S_GLRES:   ph_len = Tgl_res;
            S_ROWS:    ph_len = T_row;
            S_EXPCTRL: ph_len = Texp_ctrl;
            S_STBY:    ph_len = T_stdby;
            default:   ph_len = '0;
        endcase
        ph_done  = phase_last(cnt, ph_len);
        last_sub = ({1'b0, sub_idx} + ONE_X) >=
                   ((NUM_SUB == '0) ? ONE_X : {1'b0, NUM_SUB});
    end

    // Decode pixel controls from the current state and counters.
    always_comb begin
        d_stdby     = 1'b0;
        d_exp       = 1'b0;
        d_drain     = 1'b0;
        d_glob_res  = 1'b0;
        d_vtg_glob  = 1'b0;
        d_read_en   = 1'b0;
        d_rowmask   = 1'b0;
        d_des       = 1'b0;
        d_sync      = 1'b0;
        d_mask_en   = 1'b0;
        d_en_stream = 1'b0;
        d_rowadd    = ROWADD;
        case (state)
            S_IDLE: begin
                d_exp     = 1'b1;
                d_drain   = 1'b1;
                d_read_en = 1'b1;
                d_rowadd  = '0;
            end
            S_RST: begin
                d_stdby    = 1'b1;
                d_exp      = 1'b1;
                d_drain    = 1'b1;
                d_glob_res = 1'b1;
                d_vtg_glob = 1'b1;
                d_rowadd   = '0;
            end
            S_GLRES: begin
                d_stdby    = 1'b1;
                d_glob_res = 1'b1;
                d_rowadd   = '0;
            end
            S_ROWS: begin
                d_stdby     = 1'b1;
                d_en_stream = 1'b1;
                d_rowmask   = (slot == '0);
                d_des       = in_window(cnt, T_des_st, T_des_len);
                d_sync      = (slot == '0) && in_window(cnt, T_sync_st, T_sync_len);
                d_mask_en   = (slot == '0) && in_window(cnt, T_mask_st, T_mask_len);
                // Row address stays on the previous group while the first slot settles.
                if (!((slot == '0) && (cnt < T_hold)))
                    d_rowadd = ROW_W'({1'b0, grp} * STEP_X);
            end
            S_EXPCTRL: d_stdby = 1'b1;
            default: ;
        endcase
    end

    // Sequencer FSM with registered controls, handshake and counters.
    always_ff @(posedge CLKM or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            slot        <= '0;
            grp         <= '0;
            sub_idx     <= '0;
            trigger_o   <= 1'b0;
            busy        <= 1'b0;
            STDBY       <= 1'b0;
            EXP         <= 1'b1;
            PIXDRAIN    <= 1'b1;
            PIXGLOB_RES <= 1'b0;
            PIXVTG_GLOB <= 1'b0;
            PIXREAD_EN  <= 1'b1;
            PIXROWMASK  <= 1'b0;
            DES         <= 1'b0;
            SYNC        <= 1'b0;
            MASK_EN     <= 1'b0;
            EN_STREAM   <= 1'b0;
            ROWADD      <= '0;
        end else if (abort && (state != S_IDLE)) begin
            state       <= S_IDLE;
            cnt         <= '0;
            slot        <= '0;
            grp         <= '0;
            trigger_o   <= 1'b0;
            busy        <= 1'b0;
            STDBY       <= 1'b0;
            EXP         <= 1'b1;
            PIXDRAIN    <= 1'b1;
            PIXGLOB_RES <= 1'b0;
            PIXVTG_GLOB <= 1'b0;
            PIXREAD_EN  <= 1'b1;
            PIXROWMASK  <= 1'b0;
            DES         <= 1'b0;
            SYNC        <= 1'b0;
            MASK_EN     <= 1'b0;
            EN_STREAM   <= 1'b0;
            ROWADD      <= '0;
        end else begin
            STDBY       <= d_stdby;
            EXP         <= d_exp;
            PIXDRAIN    <= d_drain;
            PIXGLOB_RES <= d_glob_res;
            PIXVTG_GLOB <= d_vtg_glob;
            PIXREAD_EN  <= d_read_en;
            PIXROWMASK  <= d_rowmask;
            DES         <= d_des;
            SYNC        <= d_sync;
            MASK_EN     <= d_mask_en;
            EN_STREAM   <= d_en_stream;
            ROWADD      <= d_rowadd;
            case (state)
                S_IDLE: begin
                    if (!re_busy && (start || cont_mode)) begin
                        state   <= S_RST;
                        cnt     <= '0;
                        slot    <= '0;
                        grp     <= '0;
                        sub_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_RST: begin
                    slot    <= '0;
                    grp     <= '0;
                    sub_idx <= '0;
                    if (ph_done) begin
                        state <= S_GLRES;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GLRES: begin
                    if (ph_done) begin
                        state <= S_ROWS;
                        cnt   <= '0;
                        slot  <= '0;
                        grp   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ROWS: begin
                    if (!ph_done) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (slot < LAST_SLOT) begin
                            slot <= slot + 1'b1;
                        end else begin
                            slot <= '0;
                            if (grp < LAST_GROUP) begin
                                grp <= grp + 1'b1;
                            end else begin
                                grp   <= '0;
                                state <= S_EXPCTRL;
                            end
                        end
                    end
                end
                S_EXPCTRL: begin
                    if (ph_done) begin
                        cnt     <= '0;
                        slot    <= '0;
                        grp     <= '0;
                        sub_idx <= sub_idx + 1'b1;
                        state   <= last_sub ? S_STBY : S_ROWS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STBY: begin
                    if (ph_done) begin
                        state     <= S_DONE;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        trigger_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (re_busy) begin
                        state     <= S_IDLE;
                        trigger_o <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exposure_seq_param.sv
// Directed bench for exposure_seq_param with a 16-row, 3-slot geometry.
module tb_exposure_seq_param;

    localparam int CW = 32;

    logic          CLKM = 1'b0;
    logic          rst;
    logic [CW-1:0] T_reset, Tgl_res, T_row, Texp_ctrl, T_stdby;
    logic [CW-1:0] T_des_st, T_des_len, T_sync_st, T_sync_len;
    logic [CW-1:0] T_mask_st, T_mask_len, T_hold, NUM_SUB;
    logic          cont_mode, start, abort, re_busy;
    logic          trigger_o, STDBY, EXP, PIXDRAIN, PIXGLOB_RES, PIXVTG_GLOB;
    logic          PIXREAD_EN, PIXROWMASK, DES, SYNC, MASK_EN, EN_STREAM;
    logic [9:0]    ROWADD;
    logic          busy;
    logic [CW-1:0] sub_idx;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected pixel-control words {STDBY..EN_STREAM}
    localparam logic [10:0] PX_IDLE = 11'b01100100000;
    localparam logic [10:0] PX_RST  = 11'b11111000000;
    localparam logic [10:0] PX_GLR  = 11'b10010000000;
    localparam logic [10:0] PX_EXPC = 11'b10000000000;
    localparam logic [10:0] PX_STBY = 11'b00000000000;

    exposure_seq_param #(.ROW_W(10), .NUM_ROWS(16), .ROW_STEP(8),
                         .STREAM_SLOTS(3), .CNT_W(CW)) dut (
        .CLKM(CLKM), .rst(rst),
        .T_reset(T_reset), .Tgl_res(Tgl_res), .T_row(T_row),
        .Texp_ctrl(Texp_ctrl), .T_stdby(T_stdby),
        .T_des_st(T_des_st), .T_des_len(T_des_len),
        .T_sync_st(T_sync_st), .T_sync_len(T_sync_len),
        .T_mask_st(T_mask_st), .T_mask_len(T_mask_len),
        .T_hold(T_hold), .NUM_SUB(NUM_SUB),
        .cont_mode(cont_mode), .start(start), .abort(abort), .re_busy(re_busy),
        .trigger_o(trigger_o), .STDBY(STDBY), .EXP(EXP), .PIXDRAIN(PIXDRAIN),
        .PIXGLOB_RES(PIXGLOB_RES), .PIXVTG_GLOB(PIXVTG_GLOB),
        .PIXREAD_EN(PIXREAD_EN), .PIXROWMASK(PIXROWMASK), .DES(DES),
        .SYNC(SYNC), .MASK_EN(MASK_EN), .EN_STREAM(EN_STREAM),
        .ROWADD(ROWADD), .busy(busy), .sub_idx(sub_idx)
    );

    always #5 CLKM = ~CLKM;

    function automatic logic [10:0] pix();
        return {STDBY, EXP, PIXDRAIN, PIXGLOB_RES, PIXVTG_GLOB, PIXREAD_EN,
                PIXROWMASK, DES, SYNC, MASK_EN, EN_STREAM};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLKM);
        #1;
    endtask

    // Walk one subframe of ROWS outputs (2 groups x 3 slots x 10 cycles).
    task automatic rows_sweep(input string tag, inout logic [9:0] prev);
        for (int k = 0; k < 60; k++) begin
            int c, s, g;
            logic des_e, sync_e, mask_e;
            logic [9:0] ra_e;
            step();
            c = k % 10;
            s = (k / 10) % 3;
            g = k / 30;
            des_e  = (c >= 2) && (c < 5);
            sync_e = (s == 0) && (c >= 1) && (c < 3);
            mask_e = (s == 0) && (c == 0);
            ra_e   = ((s == 0) && (c < 3)) ? prev : 10'(g * 8);
            prev   = ra_e;
            chk(tag, {pix(), ROWADD},
                {6'b100000, (s == 0), des_e, sync_e, mask_e, 1'b1, ra_e});
        end
    endtask

    initial begin
        logic [9:0] prev_ra;
        rst = 1'b1;
        T_reset = 2; Tgl_res = 2; T_row = 10; Texp_ctrl = 2; T_stdby = 2;
        T_des_st = 2; T_des_len = 3; T_sync_st = 1; T_sync_len = 2;
        T_mask_st = 0; T_mask_len = 1; T_hold = 3; NUM_SUB = 2;
        cont_mode = 0; start = 0; abort = 0; re_busy = 0;
        step();
        step();
        chk("reset_pix", pix(), PX_IDLE);
        chk("reset_misc", {trigger_o, busy, ROWADD, sub_idx}, 44'd0);
        rst = 1'b0;
        step();
        chk("idle_pix", pix(), PX_IDLE);

        // Full two-subframe frame
        start = 1'b1;
        step();
        start = 1'b0;
        chk("f1_busy", {busy, trigger_o}, 2'b10);
        chk("f1_e0_pix", pix(), PX_IDLE);
        step();
        chk("f1_rst1", pix(), PX_RST);
        step();
        chk("f1_rst2", pix(), PX_RST);
        step();
        chk("f1_glr1", pix(), PX_GLR);
        step();
        chk("f1_glr2", pix(), PX_GLR);
        prev_ra = 10'd0;
        rows_sweep("f1_sub0_rows", prev_ra);
        step();
        chk("f1_exp0", {pix(), ROWADD}, {PX_EXPC, 10'd8});
        chk("f1_sub_idx0", sub_idx, 0);
        step();
        chk("f1_sub_idx1", sub_idx, 1);
        chk("f1_exp0b", pix(), PX_EXPC);
        rows_sweep("f1_sub1_rows", prev_ra);
        step();
        chk("f1_exp1", {pix(), ROWADD}, {PX_EXPC, 10'd8});
        step();
        chk("f1_sub_idx2", sub_idx, 2);
        chk("f1_no_trig", trigger_o, 1'b0);
        step();
        chk("f1_stby", {pix(), busy, trigger_o}, {PX_STBY, 2'b10});
        step();
        chk("f1_done", {busy, trigger_o}, 2'b01);

        // Handshake: trigger held while readout idle, then release and rearm
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hs_hold", trigger_o, 1'b1);
        end
        re_busy = 1'b1;
        cont_mode = 1'b1;
        step();
        chk("hs_release", {trigger_o, busy}, 2'b00);
        re_busy = 1'b0;
        step();
        chk("hs_rearm", {busy, trigger_o, PIXREAD_EN}, 3'b101);
        cont_mode = 1'b0;

        // Abort inside group 1 of the rearmed frame
        repeat (35) step();
        chk("ab_pre", {EN_STREAM, PIXROWMASK, ROWADD}, {2'b11, 10'd0});
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_idle", {pix(), ROWADD, busy, trigger_o}, {PX_IDLE, 10'd0, 2'b00});
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ab_quiet", {busy, trigger_o}, 2'b00);
        end

        // Zero-length phases and NUM_SUB=0
        T_reset = 0; Tgl_res = 0; Texp_ctrl = 0; T_stdby = 0; NUM_SUB = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("z_busy", busy, 1'b1);
        step();
        chk("z_rst", pix(), PX_RST);
        step();
        chk("z_glr", pix(), PX_GLR);
        step();
        chk("z_rows_first", EN_STREAM, 1'b1);
        repeat (59) step();
        chk("z_rows_last", EN_STREAM, 1'b1);
        step();
        chk("z_exp", {pix(), trigger_o}, {PX_EXPC, 1'b0});
        chk("z_sub_idx", sub_idx, 1);
        step();
        chk("z_done", {pix(), trigger_o, busy}, {PX_STBY, 2'b10});
        chk("z_one_sub", sub_idx, 1);
        re_busy = 1'b1;
        step();
        re_busy = 1'b0;
        chk("z_release", trigger_o, 1'b0);

        // Asynchronous reset in the middle of the second EXPCTRL phase
        Texp_ctrl = 20; NUM_SUB = 2;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (145) step();
        chk("ar_pre", {pix(), sub_idx}, {PX_EXPC, 32'd1});
        #2;
        rst = 1'b1;
        #1;
        chk("ar_pix", pix(), PX_IDLE);
        chk("ar_misc", {sub_idx, busy, trigger_o, ROWADD}, 44'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ar_stay_idle", {pix(), busy}, {PX_IDLE, 1'b0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
